seven_seg_scanner: RTL and testbench

Parametrised multiplexed seven-segment display driver. It scans NUM_DIGITS common-anode digits from a packed vector of 5-bit character codes. A built-in refresh prescaler sets the scan rate; frame-synchronous shadow registers prevent tearing. It also provides per-digit blanking, decimal points, leading-zero suppression and PWM brightness control. It sits between the lock controller's display vector and the board's AN/segment pins, and replaces the fixed 4-digit free-running scanner.

---
 rtl/seven_seg_scanner.sv | 144 ++++++++++++++
 tb/tb_seven_seg_scanner.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scanner.sv
// Multiplexed seven-segment scanner: refresh prescaler, frame-synchronous shadow
// registers, blanking, decimal points, leading-zero suppression and PWM brightness.
module seven_seg_scanner #(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 50000,
   parameter int DUTY_BITS   = 4,
   parameter int ACTIVE_LOW  = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [5*NUM_DIGITS-1:0] digits,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   blank_in,
   input  logic                    lz_en,
   input  logic [DUTY_BITS-1:0]    duty,
   output logic [NUM_DIGITS-1:0]   AN,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic                    frame_tick
);

   localparam int PRESC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IDX_W   = $clog2(NUM_DIGITS);
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
   localparam logic               INV        = (ACTIVE_LOW != 0);

   function automatic logic [6:0] decode(input logic [4:0] code);
      case (code)
         5'h00:   return 7'h3F;
         5'h01:   return 7'h06;
         5'h02:   return 7'h5B;
         5'h03:   return 7'h4F;
         5'h04:   return 7'h66;
         5'h05:   return 7'h6D;
         5'h06:   return 7'h7D;
         5'h07:   return 7'h07;
         5'h08:   return 7'h7F;
         5'h09:   return 7'h6F;
         5'h0A:   return 7'h77;
         5'h0B:   return 7'h7C;
         5'h0C:   return 7'h39;
         5'h0D:   return 7'h5E;
         5'h0E:   return 7'h79;
         5'h0F:   return 7'h71;
         5'h11:   return 7'h40;
         5'h12:   return 7'h38;
         5'h13:   return 7'h73;
         5'h14:   return 7'h5C;
         default: return 7'h00;
      endcase
   endfunction

   logic [PRESC_W-1:0]    presc_q, presc_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [4:0]            sh_code_q [NUM_DIGITS];
   logic [NUM_DIGITS-1:0] sh_dp_q, sh_blank_q;
   logic [NUM_DIGITS-1:0] an_q, an_d;
   logic [6:0]            seg_q, seg_d;
   logic                  dpo_q, dpo_d;
   logic                  tick_q;

   logic                  slot_end, frame_end;
   logic [NUM_DIGITS-1:0] lz_sup;
   logic                  dark;

   assign slot_end  = (presc_q == PRESC_LAST);
   assign frame_end = slot_end && (idx_q == IDX_LAST);

   always_comb begin
      presc_d = presc_q + 1'b1;
      idx_d   = idx_q;
      if (slot_end) begin
         presc_d = '0;
         idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end
   end

   // A zero is suppressed only while every digit above it is also zero.
   always_comb begin : lz_scan
      logic zrun;
      zrun   = 1'b1;
      lz_sup = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zrun = zrun & (sh_code_q[i] == 5'h00);
         if (i != 0) lz_sup[i] = lz_en & zrun;
      end
   end

   always_comb begin
      dark  = sh_blank_q[idx_q] | lz_sup[idx_q];
      an_d  = '0;
      seg_d = 7'h00;
      dpo_d = 1'b0;
      if (!dark) begin
         seg_d        = decode(sh_code_q[idx_q]);
         dpo_d        = sh_dp_q[idx_q];
         an_d[idx_q]  = (presc_q[DUTY_BITS-1:0] <= duty);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_q <= '0;
         idx_q   <= '0;
      end else begin
         presc_q <= presc_d;
         idx_q   <= idx_d;
      end
   end

   // Inputs are only captured at the frame boundary so a frame never tears.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_DIGITS; i++) sh_code_q[i] <= 5'h10;
         sh_dp_q    <= '0;
         sh_blank_q <= '1;
      end else if (frame_end) begin
         for (int i = 0; i < NUM_DIGITS; i++) sh_code_q[i] <= digits[5*i +: 5];
         sh_dp_q    <= dp_in;
         sh_blank_q <= blank_in;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         an_q   <= {NUM_DIGITS{INV}};
         seg_q  <= {7{INV}};
         dpo_q  <= INV;
         tick_q <= 1'b0;
      end else begin
         an_q   <= an_d ^ {NUM_DIGITS{INV}};
         seg_q  <= seg_d ^ {7{INV}};
         dpo_q  <= dpo_d ^ INV;
         tick_q <= frame_end;
      end
   end

   assign AN         = an_q;
   assign seg        = seg_q;
   assign dp         = dpo_q;
   assign frame_tick = tick_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner: a cycle-count reference model queues the
// expected pin state after every clock edge and a monitor compares on the falling edge.
module tb_seven_seg_scanner;

   localparam int N  = 4;
   localparam int RD = 16;
   localparam int DB = 4;
   localparam int FR = N * RD;

   typedef struct packed {
      logic [N-1:0] an;
      logic [6:0]   seg;
      logic         dp;
      logic         ft;
   } obs_t;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [5*N-1:0] digits;
   logic [N-1:0]   dp_in, blank_in;
   logic           lz_en;
   logic [DB-1:0]  duty;
   logic [N-1:0]   AN;
   logic [6:0]     seg;
   logic           dp;
   logic           frame_tick;

   seven_seg_scanner #(
      .NUM_DIGITS (N),
      .REFRESH_DIV(RD),
      .DUTY_BITS  (DB),
      .ACTIVE_LOW (1)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .digits    (digits),
      .dp_in     (dp_in),
      .blank_in  (blank_in),
      .lz_en     (lz_en),
      .duty      (duty),
      .AN        (AN),
      .seg       (seg),
      .dp        (dp),
      .frame_tick(frame_tick)
   );

   always #5 clk = ~clk;

   logic [6:0]  seg_tab [32];
   obs_t        exp_q [$];
   int          n_vec = 0;
   int          n_err = 0;

   // Reference model state: cycles since reset release plus the latched frame.
   int unsigned mc;
   logic [4:0]  m_code [N];
   logic [N-1:0] m_dp, m_blank;

   always @(posedge rst) exp_q.delete();

   always @(posedge clk) begin
      obs_t e;
      int   presc, idx, hi;
      bit   dark;
      if (rst) begin
         mc = 0;
         for (int i = 0; i < N; i++) m_code[i] = 5'h10;
         m_dp    = '0;
         m_blank = '1;
         e.an = '1; e.seg = 7'h7F; e.dp = 1'b1; e.ft = 1'b0;
      end else begin
         presc = int'(mc % RD);
         idx   = int'((mc / RD) % N);
         hi    = -1;
         for (int i = 0; i < N; i++) if (m_code[i] != 5'h00) hi = i;
         dark  = m_blank[idx] || (lz_en && idx > hi && idx != 0);
         e.an = '1; e.seg = 7'h7F; e.dp = 1'b1;
         if (!dark) begin
            e.seg = ~seg_tab[m_code[idx]];
            e.dp  = ~m_dp[idx];
            if ((presc % (1 << DB)) <= int'(duty)) e.an[idx] = 1'b0;
         end
         e.ft = (mc % FR == FR - 1);
         if (e.ft) begin
            for (int i = 0; i < N; i++) m_code[i] = digits[5*i +: 5];
            m_dp    = dp_in;
            m_blank = blank_in;
         end
         mc++;
      end
      exp_q.push_back(e);
   end

   always @(negedge clk) begin
      obs_t e, g;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = {AN, seg, dp, frame_tick};
         n_vec++;
         if (g !== e) begin
            n_err++;
            $display("FAIL pins t=%0t got AN=%b seg=%h dp=%b ft=%b, want AN=%b seg=%h dp=%b ft=%b",
                     $time, g.an, g.seg, g.dp, g.ft, e.an, e.seg, e.dp, e.ft);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s got=%0h want=%0h", name, got, want);
      end
   endtask

   task automatic run(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_ft(output int k);
      k = 0;
      for (int i = 1; i <= 200; i++) begin
         @(negedge clk);
         if (frame_tick) begin
            k = i;
            break;
         end
      end
   endtask

   function automatic logic [5*N-1:0] rand_digits();
      logic [5*N-1:0] d;
      for (int i = 0; i < N; i++)
         d[5*i +: 5] = ($urandom_range(0, 1) == 0) ? 5'h00 : 5'($urandom_range(0, 31));
      return d;
   endfunction

   initial begin
      #400000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      for (int i = 0; i < 32; i++) seg_tab[i] = 7'h00;
      seg_tab[0]  = 7'h3F; seg_tab[1]  = 7'h06; seg_tab[2]  = 7'h5B; seg_tab[3]  = 7'h4F;
      seg_tab[4]  = 7'h66; seg_tab[5]  = 7'h6D; seg_tab[6]  = 7'h7D; seg_tab[7]  = 7'h07;
      seg_tab[8]  = 7'h7F; seg_tab[9]  = 7'h6F; seg_tab[10] = 7'h77; seg_tab[11] = 7'h7C;
      seg_tab[12] = 7'h39; seg_tab[13] = 7'h5E; seg_tab[14] = 7'h79; seg_tab[15] = 7'h71;
      seg_tab[17] = 7'h40; seg_tab[18] = 7'h38; seg_tab[19] = 7'h73; seg_tab[20] = 7'h5C;

      digits   = {5'h00, 5'h08, 5'h01, 5'h02};
      dp_in    = '0;
      blank_in = '0;
      lz_en    = 1'b0;
      duty     = 4'hF;
      run(3);
      rst = 1'b0;

      wait_ft(k);
      check("first_tick", k, 64);
      wait_ft(k);
      check("tick_period", k, 64);
      run(FR + 4);

      // digits changing at arbitrary points inside frames
      for (int i = 0; i < 12; i++) begin
         run($urandom_range(5, 30));
         digits = 20'($urandom);
      end

      lz_en  = 1'b1;
      digits = '0;
      run(2 * FR);
      digits = {5'h00, 5'h00, 5'h05, 5'h00};
      run(2 * FR);
      lz_en  = 1'b0;

      digits = {5'h03, 5'h02, 5'h01, 5'h00};
      duty   = 4'd3;
      run(2 * FR);
      duty   = 4'd0;
      run(2 * FR);
      for (int i = 0; i < FR; i++) begin
         duty = 4'($urandom);
         run(1);
      end
      duty = 4'hF;

      blank_in = 4'b0100;
      dp_in    = 4'b0101;
      digits   = {5'h12, 5'h13, 5'h11, 5'h14};
      run(2 * FR);

      for (int i = 0; i < 60; i++) begin
         digits   = rand_digits();
         dp_in    = 4'($urandom);
         blank_in = 4'($urandom_range(0, 3)) & 4'($urandom);
         lz_en    = 1'($urandom);
         duty     = 4'($urandom);
         run($urandom_range(1, 40));
      end

      // asynchronous reset landing in the middle of digit 2's slot
      blank_in = '0;
      dp_in    = '0;
      lz_en    = 1'b0;
      duty     = 4'hF;
      digits   = {5'h07, 5'h08, 5'h09, 5'h0A};
      wait_ft(k);
      wait_ft(k);
      run(2 * RD + 5);
      #2 rst = 1'b1;
      #1 check("rst_async", 32'({AN, seg, dp, frame_tick}), 32'({4'hF, 7'h7F, 1'b1, 1'b0}));
      run(3);
      rst = 1'b0;
      wait_ft(k);
      check("tick_after_rst", k, 64);
      run(FR + 8);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
